// File: rtl/hazard_stall_controller.sv
// Decode-stage hazard sequencer: stall/flush controls for PC and pipeline registers
// for load-use, mul/div occupancy, data-memory wait and taken-branch squash.
module hazard_stall_controller #(
    parameter int LOAD_BUBBLES = 2,
    parameter int MD_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_muldiv,
    input  logic             muldiv_done,
    input  logic             ex_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic             md_timeout,
    output logic [1:0]       ctrl_state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MD_WAIT  = 2'b10
    } state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_LU  = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_MD  = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1,
                                   ex_mem_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_FRZ = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1,
                                   ex_mem_stall: 1'b1, mem_wb_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_BR  = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};

    localparam logic [1:0]  LB_INIT = 2'(LOAD_BUBBLES - 1);
    localparam logic [15:0] MD_LIM  = 16'(MD_TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  bub_q, bub_d;
    logic [15:0] tmr_q, tmr_d;
    logic        md_to_d;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t       ctrl;
    logic        load_use;

    assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        bub_d   = bub_q;
        tmr_d   = tmr_q;
        md_to_d = md_timeout;
        if (dmem_busy) begin
            // EX/ID are held, so whatever hazard is pending gets re-evaluated afterwards
            ctrl = CTRL_FRZ;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        ctrl = CTRL_BR;
                    end else if (ex_muldiv && !muldiv_done) begin
                        ctrl    = CTRL_MD;
                        state_d = MD_WAIT;
                        tmr_d   = '0;
                    end else if (load_use) begin
                        ctrl = CTRL_LU;
                        if (LOAD_BUBBLES > 1) begin
                            state_d = LU_STALL;
                            bub_d   = LB_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    ctrl = CTRL_LU;
                    if (bub_q <= 2'd1) begin
                        state_d = RUN;
                        bub_d   = '0;
                    end else begin
                        bub_d = bub_q - 2'd1;
                    end
                end
                MD_WAIT: begin
                    if (muldiv_done) begin
                        state_d = RUN;
                        tmr_d   = '0;
                    end else begin
                        ctrl = CTRL_MD;
                        if (tmr_q != 16'hFFFF) tmr_d = tmr_q + 16'd1;
                        if (tmr_d >= MD_LIM) md_to_d = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            bub_q      <= '0;
            tmr_q      <= '0;
            md_timeout <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            bub_q      <= bub_d;
            tmr_q      <= tmr_d;
            md_timeout <= md_to_d;
            if (ctrl.pc_stall && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Controls are combinational, so gate them directly with reset.
    assign pc_stall     = rst_n & ctrl.pc_stall;
    assign if_id_stall  = rst_n & ctrl.if_id_stall;
    assign id_ex_stall  = rst_n & ctrl.id_ex_stall;
    assign ex_mem_stall = rst_n & ctrl.ex_mem_stall;
    assign if_id_flush  = rst_n & ctrl.if_id_flush;
    assign id_ex_flush  = rst_n & ctrl.id_ex_flush;
    assign ex_mem_flush = rst_n & ctrl.ex_mem_flush;
    assign mem_wb_flush = rst_n & ctrl.mem_wb_flush;
    assign stall_count  = cnt_q;
    assign ctrl_state   = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: LOAD_BUBBLES=2, MD_TIMEOUT=4, 3-bit stall counter.
module tb_hazard_stall_controller;

    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_muldiv, muldiv_done, ex_branch_taken, dmem_busy;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [CNT_W-1:0] stall_count;
    logic md_timeout;
    logic [1:0] ctrl_state;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc, if_id, id_ex, ex_mem stall, if_id, id_ex, ex_mem, mem_wb flush}
    wire [7:0] ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                      if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1100_0100;
    localparam logic [7:0] MD   = 8'b1110_0010;
    localparam logic [7:0] FRZ  = 8'b1111_0001;
    localparam logic [7:0] BR   = 8'b0000_1100;

    hazard_stall_controller #(.LOAD_BUBBLES(2), .MD_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
        .ex_muldiv(ex_muldiv), .muldiv_done(muldiv_done),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .stall_count(stall_count), .md_timeout(md_timeout), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic idle();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_muldiv = 1'b0; muldiv_done = 1'b0; ex_branch_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    // load x5 in EX, ID reads rs2=x5
    task automatic drive_load_use();
        idle();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        dmem_busy = 1'b1; ex_muldiv = 1'b1; ex_branch_taken = 1'b1;
        #1;
        n_tests++; if (ctl !== NONE) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, NONE); end
        n_tests++; if (ctrl_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got=%b exp=00", ctrl_state); end
        n_tests++; if (stall_count !== 3'd0 || md_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt got=%0d/%b exp=0/0", stall_count, md_timeout); end
        idle();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); drive_load_use(); #1;
        n_tests++; if (ctl !== LU || ctrl_state !== 2'b00) begin
            n_fail++; $display("FAIL lu_c0 got=%b/%b exp=%b/00", ctl, ctrl_state, LU); end
        @(negedge clk); idle(); #1;
        n_tests++; if (ctl !== LU || ctrl_state !== 2'b01) begin
            n_fail++; $display("FAIL lu_c1 got=%b/%b exp=%b/01", ctl, ctrl_state, LU); end
        @(negedge clk); #1;
        n_tests++; if (ctl !== NONE || ctrl_state !== 2'b00 || stall_count !== 3'd2) begin
            n_fail++; $display("FAIL lu_end got=%b/%b/%0d exp=%b/00/2", ctl, ctrl_state, stall_count, NONE); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        @(negedge clk); idle(); ex_mem_read = 1'b1; id_uses_rs1 = 1'b1; #1;
        n_tests++; if (ctl !== NONE) begin n_fail++; $display("FAIL x0_load got=%b exp=%b", ctl, NONE); end
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5;
        id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1; #1;
        n_tests++; if (ctl !== NONE) begin n_fail++; $display("FAIL rs1_unused got=%b exp=%b", ctl, NONE); end
        @(negedge clk); ex_mem_read = 1'b0; id_uses_rs1 = 1'b1; #1;
        n_tests++; if (ctl !== NONE) begin n_fail++; $display("FAIL not_load got=%b exp=%b", ctl, NONE); end
        @(negedge clk); ex_mem_read = 1'b1; #1;
        n_tests++; if (ctl !== LU) begin n_fail++; $display("FAIL rs1_hazard got=%b exp=%b", ctl, LU); end
        @(negedge clk); idle(); #1;
        n_tests++; if (ctl !== LU || ctrl_state !== 2'b01) begin
            n_fail++; $display("FAIL rs1_bubble got=%b/%b exp=%b/01", ctl, ctrl_state, LU); end
        @(negedge clk); #1;
        n_tests++; if (stall_count !== 3'd2 || ctrl_state !== 2'b00) begin
            n_fail++; $display("FAIL no_hazard_cnt got=%0d/%b exp=2/00", stall_count, ctrl_state); end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk); drive_load_use(); ex_branch_taken = 1'b1; #1;
        n_tests++; if (ctl !== BR || ctrl_state !== 2'b00) begin
            n_fail++; $display("FAIL branch got=%b/%b exp=%b/00", ctl, ctrl_state, BR); end
        @(negedge clk); idle(); #1;
        n_tests++; if (ctl !== NONE || ctrl_state !== 2'b00 || stall_count !== 3'd0) begin
            n_fail++; $display("FAIL branch_after got=%b/%b/%0d exp=%b/00/0", ctl, ctrl_state, stall_count, NONE); end
    endtask

    task automatic test_muldiv();
        do_reset();
        @(negedge clk); idle(); ex_muldiv = 1'b1; #1;
        n_tests++; if (ctl !== MD || ctrl_state !== 2'b00) begin
            n_fail++; $display("FAIL md_c0 got=%b/%b exp=%b/00", ctl, ctrl_state, MD); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1;
            n_tests++; if (ctl !== MD || ctrl_state !== 2'b10) begin
                n_fail++; $display("FAIL md_c%0d got=%b/%b exp=%b/10", i, ctl, ctrl_state, MD); end
        end
        n_tests++; if (md_timeout !== 1'b0) begin n_fail++; $display("FAIL md_to_early got=%b exp=0", md_timeout); end
        @(negedge clk); muldiv_done = 1'b1; #1;
        n_tests++; if (ctl !== NONE || ctrl_state !== 2'b10 || md_timeout !== 1'b1) begin
            n_fail++; $display("FAIL md_done got=%b/%b/%b exp=%b/10/1", ctl, ctrl_state, md_timeout, NONE); end
        @(negedge clk); idle(); #1;
        n_tests++; if (ctrl_state !== 2'b00 || stall_count !== 3'd5) begin
            n_fail++; $display("FAIL md_end got=%b/%0d exp=00/5", ctrl_state, stall_count); end
        do_reset();
        @(negedge clk); ex_muldiv = 1'b1; muldiv_done = 1'b1; #1;
        n_tests++; if (ctl !== NONE) begin n_fail++; $display("FAIL md_same got=%b exp=%b", ctl, NONE); end
        @(negedge clk); idle(); #1;
        n_tests++; if (ctrl_state !== 2'b00 || stall_count !== 3'd0) begin
            n_fail++; $display("FAIL md_same_end got=%b/%0d exp=00/0", ctrl_state, stall_count); end
    endtask

    task automatic test_freeze();
        do_reset();
        @(negedge clk); drive_load_use(); #1;
        n_tests++; if (ctl !== LU) begin n_fail++; $display("FAIL frz_c0 got=%b exp=%b", ctl, LU); end
        @(negedge clk); idle(); dmem_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            n_tests++; if (ctl !== FRZ || ctrl_state !== 2'b01) begin
                n_fail++; $display("FAIL frz_c%0d got=%b/%b exp=%b/01", i, ctl, ctrl_state, FRZ); end
        end
        @(negedge clk); dmem_busy = 1'b0; #1;
        n_tests++; if (ctl !== LU || ctrl_state !== 2'b01) begin
            n_fail++; $display("FAIL frz_resume got=%b/%b exp=%b/01", ctl, ctrl_state, LU); end
        @(negedge clk); #1;
        n_tests++; if (ctl !== NONE || ctrl_state !== 2'b00 || stall_count !== 3'd5) begin
            n_fail++; $display("FAIL frz_end got=%b/%b/%0d exp=%b/00/5", ctl, ctrl_state, stall_count, NONE); end
        // branch held under freeze is taken once memory releases
        @(negedge clk); ex_branch_taken = 1'b1; dmem_busy = 1'b1; #1;
        n_tests++; if (ctl !== FRZ) begin n_fail++; $display("FAIL frz_branch got=%b exp=%b", ctl, FRZ); end
        @(negedge clk); dmem_busy = 1'b0; #1;
        n_tests++; if (ctl !== BR || ctrl_state !== 2'b00) begin
            n_fail++; $display("FAIL frz_branch_rel got=%b/%b exp=%b/00", ctl, ctrl_state, BR); end
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge clk); idle(); ex_muldiv = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        n_tests++; if (stall_count !== 3'd7) begin n_fail++; $display("FAIL cnt_sat got=%0d exp=7", stall_count); end
    endtask

    task automatic test_timeout_reset();
        do_reset();
        @(negedge clk); idle(); ex_muldiv = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        n_tests++; if (md_timeout !== 1'b1 || ctl !== MD || ctrl_state !== 2'b10) begin
            n_fail++; $display("FAIL to_rise got=%b/%b/%b exp=1/%b/10", md_timeout, ctl, ctrl_state, MD); end
        @(negedge clk); #1;
        n_tests++; if (md_timeout !== 1'b1 || ctl !== MD) begin
            n_fail++; $display("FAIL to_sticky got=%b/%b exp=1/%b", md_timeout, ctl, MD); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (ctl !== NONE || ctrl_state !== 2'b00 || md_timeout !== 1'b0 || stall_count !== 3'd0) begin
            n_fail++; $display("FAIL to_reset got=%b/%b/%b/%0d exp=%b/00/0/0", ctl, ctrl_state, md_timeout, stall_count, NONE); end
        @(negedge clk); idle(); rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_muldiv();
        test_freeze();
        test_saturate();
        test_timeout_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Per-core pipeline sequencer that generates the stall and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Covers the hazards that operand forwarding cannot resolve: load-use, multi-cycle mul/div occupancy of EX, data-memory wait, and taken-branch squash.
- Sits in the decode stage beside the forwarding unit. It also keeps a stall-cycle performance counter and a sticky mul/div watchdog flag.

Parameters:
- LOAD_BUBBLES, 2, number of bubbles inserted for a load-use hazard; legal range 1..3. The MEM forwarding path carries the ALU result, not load data.
- MD_TIMEOUT, 64, MD_WAIT cycles after which md_timeout sets; legal range 1..65535.
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1_addr  in  5  rs1 of the instruction in ID
- id_rs2_addr  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd_addr  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_muldiv  in  1  EX holds a valid multi-cycle mul/div
- muldiv_done  in  1  mul/div result valid this cycle
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- dmem_busy  in  1  MEM-stage access not complete this cycle
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the register
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble
- stall_count  out  CNT_W  cycles with pc_stall=1, saturating
- md_timeout  out  1  sticky watchdog flag
- ctrl_state  out  2  00 RUN, 01 LU_STALL, 10 MD_WAIT

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to RUN. The bubble counter, stall_count, the MD_WAIT timer and md_timeout all clear.
  - All stall and flush outputs are forced 0 while rst_n is low, regardless of inputs.
  - Reset mid-operation abandons the sequence with no recovery cycle.
- Controls are combinational from the current state and inputs; state and counters update on the rising edge of clk.
- FREEZE (dmem_busy=1) has top priority in every state:
  - Asserts pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush. All other flushes are 0.
  - State, bubble counter and MD_WAIT timer hold.
  - A taken branch or hazard present during FREEZE is re-evaluated once dmem_busy drops, because EX and ID are held.
- RUN, no FREEZE, evaluated in priority order:
  1. ex_branch_taken: assert if_id_flush and id_ex_flush for 1 cycle. Stay in RUN; a coincident load-use hazard is ignored.
  2. ex_muldiv and not muldiv_done: assert pc_stall, if_id_stall, id_ex_stall and ex_mem_flush; next state MD_WAIT. If ex_muldiv and muldiv_done are both high, no stall.
  3. Load-use, defined as ex_mem_read, ex_rd_addr!=0, and a used rs1 or rs2 equal to ex_rd_addr:
     - Assert pc_stall, if_id_stall and id_ex_flush.
     - If LOAD_BUBBLES>1: go to LU_STALL with counter = LOAD_BUBBLES-1. Otherwise stay in RUN.
  4. Otherwise all controls are 0.
- LU_STALL: assert pc_stall, if_id_stall and id_ex_flush, then decrement the counter. When the counter is 1 at the edge, next state is RUN.
- MD_WAIT:
  - While muldiv_done=0: assert pc_stall, if_id_stall, id_ex_stall and ex_mem_flush, and increment the timer (saturating at 16 bits).
  - When muldiv_done=1: all controls are 0, next state is RUN, and the timer clears.
  - When the timer reaches MD_TIMEOUT, md_timeout sets and stays set until reset. Stalling continues.
- stall_count increments on every edge where pc_stall=1, including FREEZE cycles, and saturates at all-ones.
- Never assert stall and flush on the same register in the same cycle.

Test Plan:
- Load x5 in EX, ID reads rs2=x5 with uses_rs2=1, LOAD_BUBBLES=2 → 2 cycles of pc_stall/if_id_stall/id_ex_flush, ctrl_state 00→01→00, stall_count=2.
- Load to x0 in EX, ID reads x0 → no stall. Same load but id_uses_rs1=0 → no stall.
- Taken branch with a simultaneous load-use hazard → one cycle of if_id_flush=id_ex_flush=1, no stall, state stays RUN.
- ex_muldiv with muldiv_done arriving 5 cycles later → 5 cycles of id_ex_stall/ex_mem_flush, release in the done cycle, stall_count=5. Done in the same cycle → 0 stalls.
- dmem_busy for 3 cycles arriving in the first LU_STALL cycle → freeze pattern with mem_wb_flush=1, counter held, then the remaining bubble. Total pc_stall count = 2+3 = 5.
- MD_TIMEOUT=4 with done never asserted → md_timeout rises after 4 MD_WAIT cycles and stays high. rst_n pulsed low mid-wait → all outputs 0 immediately, state RUN, md_timeout=0.
